// File: rtl/brisc_pkg.sv
// Shared definitions for the register file / load scoreboard slice.
package brisc_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 4;
  localparam int NREGS      = 2 ** ADDR_W_DEF;

  // Ceiling log2 usable in constant expressions (port widths, localparams).
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/reg_bypass_mux.sv
// One read port: array word overridden by same-cycle load or ALU write-back.
module reg_bypass_mux
  import brisc_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int R0_ZERO = 1
) (
  input  logic [ADDR_W-1:0] src,
  input  logic [DATA_W-1:0] arr_word,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] data
);

  // Lowest priority first; later assignments override. Load return beats
  // ALU write-back, and a hard-wired zero r0 beats everything.
  always_comb begin
    data = arr_word;
    if (wb_valid && (wb_addr == src)) data = wb_data;
    if (ld_valid && (ld_addr == src)) data = ld_data;
    if ((R0_ZERO != 0) && (src == '0)) data = '0;
  end

endmodule

// File: rtl/reg_scoreboard_file.sv
// Register file with per-register busy scoreboard for in-flight loads,
// write-back bypass on the read ports and an issue_ready hazard signal.
//
// Issue handshake: an instruction transfers on a rising edge where
// issue_valid && issue_ready. issue_ready is purely combinational from the
// scoreboard, the issue fields and the load-return strobe; it never looks at
// issue_valid, so decode may hold or drop issue_valid freely while stalled.
module reg_scoreboard_file
  import brisc_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int NREAD     = 2,
  parameter int MAX_LOADS = 2,
  parameter int R0_ZERO   = 1
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             issue_valid,
  input  logic [NREAD*ADDR_W-1:0]          issue_src,
  input  logic [ADDR_W-1:0]                issue_dst,
  input  logic                             issue_is_load,
  output logic                             issue_ready,
  output logic [NREAD*DATA_W-1:0]          rd_data,
  input  logic                             wb_valid,
  input  logic [ADDR_W-1:0]                wb_addr,
  input  logic [DATA_W-1:0]                wb_data,
  input  logic                             ld_valid,
  input  logic [ADDR_W-1:0]                ld_addr,
  input  logic [DATA_W-1:0]                ld_data,
  output logic [clog2(MAX_LOADS+1)-1:0]    load_count,
  output logic                             err
);

  localparam int NR    = 1 << ADDR_W;
  localparam int CNT_W = clog2(MAX_LOADS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOADS);

  logic [DATA_W-1:0] regs [NR];
  logic [NR-1:0]     busy;
  logic [NR-1:0]     ld_hit;
  logic [NR-1:0]     eff_busy;
  logic              src_hazard;
  logic              cnt_full;
  logic              dst_is_r0;
  logic              issue_fire;
  logic              ld_ok;
  logic              err_set;
  logic              wb_we;
  logic              ld_we;

  // Effective busy: a load returning this cycle no longer blocks consumers.
  always_comb begin
    ld_hit = '0;
    if (ld_valid) ld_hit[ld_addr] = 1'b1;
    eff_busy = busy & ~ld_hit;
  end

  // Hazard detection: RAW on any source, WAW on dst, and load-slot exhaustion.
  always_comb begin
    src_hazard = 1'b0;
    for (int i = 0; i < NREAD; i++) begin
      if (eff_busy[issue_src[i*ADDR_W +: ADDR_W]]) src_hazard = 1'b1;
    end
    cnt_full    = (load_count == CNT_MAX);
    issue_ready = !src_hazard && !eff_busy[issue_dst] &&
                  !(issue_is_load && cnt_full && !ld_valid);
  end

  // Per-cycle commit decisions shared by the state registers below.
  always_comb begin
    dst_is_r0  = (R0_ZERO != 0) && (issue_dst == '0);
    issue_fire = issue_valid && issue_ready && issue_is_load && !dst_is_r0;
    ld_ok      = ld_valid && busy[ld_addr];
    wb_we      = wb_valid && !((R0_ZERO != 0) && (wb_addr == '0));
    ld_we      = ld_valid && !((R0_ZERO != 0) && (ld_addr == '0));
    err_set    = (ld_valid && !busy[ld_addr]) ||
                 (ld_valid && wb_valid && (ld_addr == wb_addr)) ||
                 (wb_valid && busy[wb_addr]);
  end

  // Architectural array; the load write is placed last so it wins a collision.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int r = 0; r < NR; r++) regs[r] <= '0;
    end else begin
      if (wb_we) regs[wb_addr] <= wb_data;
      if (ld_we) regs[ld_addr] <= ld_data;
    end
  end

  // Busy scoreboard; setting is placed after clearing so set wins.
  always_ff @(posedge CLK) begin
    if (RST) begin
      busy <= '0;
    end else begin
      if (ld_valid)   busy[ld_addr]   <= 1'b0;
      if (issue_fire) busy[issue_dst] <= 1'b1;
    end
  end

  // Outstanding-load counter; only matched returns decrement it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      load_count <= '0;
    end else begin
      case ({issue_fire, ld_ok})
        2'b10:   load_count <= load_count + CNT_W'(1);
        2'b01:   load_count <= load_count - CNT_W'(1);
        default: load_count <= load_count;
      endcase
    end
  end

  // Sticky protocol-error flag, cleared only by reset.
  always_ff @(posedge CLK) begin
    if (RST)          err <= 1'b0;
    else if (err_set) err <= 1'b1;
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_read
    reg_bypass_mux #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .R0_ZERO(R0_ZERO)
    ) u_mux (
      .src     (issue_src[i*ADDR_W +: ADDR_W]),
      .arr_word(regs[issue_src[i*ADDR_W +: ADDR_W]]),
      .wb_valid(wb_valid),
      .wb_addr (wb_addr),
      .wb_data (wb_data),
      .ld_valid(ld_valid),
      .ld_addr (ld_addr),
      .ld_data (ld_data),
      .data    (rd_data[i*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_reg_scoreboard_file.sv
// Self-checking bench for reg_scoreboard_file (default parameters).
module tb_reg_scoreboard_file;

  logic        CLK;
  logic        RST;
  logic        issue_valid;
  logic [7:0]  issue_src;
  logic [3:0]  issue_dst;
  logic        issue_is_load;
  logic        issue_ready;
  logic [31:0] rd_data;
  logic        wb_valid;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic        ld_valid;
  logic [3:0]  ld_addr;
  logic [15:0] ld_data;
  logic [1:0]  load_count;
  logic        err;

  int n_cmp;
  int n_bad;

  // Reference model: architectural values, pending-load set, counters.
  logic [15:0] m_regs [16];
  bit          m_busy [16];
  int          m_cnt;
  bit          m_err;

  reg_scoreboard_file dut (
    .CLK(CLK), .RST(RST),
    .issue_valid(issue_valid), .issue_src(issue_src), .issue_dst(issue_dst),
    .issue_is_load(issue_is_load), .issue_ready(issue_ready), .rd_data(rd_data),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .load_count(load_count), .err(err)
  );

  // Clock and reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // ---------------- model ----------------
  function automatic logic [15:0] m_read(input int a);
    if (a == 0) return 16'h0000;
    if (ld_valid && int'(ld_addr) == a) return ld_data;
    if (wb_valid && int'(wb_addr) == a) return wb_data;
    return m_regs[a];
  endfunction

  function automatic bit m_stalled_on(input int r);
    return m_busy[r] && !(ld_valid && int'(ld_addr) == r);
  endfunction

  function automatic bit m_ready();
    if (m_stalled_on(int'(issue_src[3:0]))) return 1'b0;
    if (m_stalled_on(int'(issue_src[7:4]))) return 1'b0;
    if (m_stalled_on(int'(issue_dst))) return 1'b0;
    if (issue_is_load && m_cnt == 2 && !ld_valid) return 1'b0;
    return 1'b1;
  endfunction

  task automatic m_commit();
    bit fire;
    bit ret_ok;
    fire   = issue_valid && m_ready() && issue_is_load && issue_dst != 4'd0;
    ret_ok = ld_valid && m_busy[ld_addr];
    if (ld_valid && !m_busy[ld_addr]) m_err = 1'b1;
    if (ld_valid && wb_valid && ld_addr == wb_addr) m_err = 1'b1;
    if (wb_valid && m_busy[wb_addr]) m_err = 1'b1;
    if (wb_valid && wb_addr != 4'd0) m_regs[wb_addr] = wb_data;
    if (ld_valid && ld_addr != 4'd0) m_regs[ld_addr] = ld_data;
    if (ld_valid) m_busy[ld_addr] = 1'b0;
    if (fire) m_busy[issue_dst] = 1'b1;
    m_cnt = m_cnt + int'(fire) - int'(ret_ok);
  endtask

  task automatic m_reset();
    for (int r = 0; r < 16; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 1'b0;
    end
    m_cnt = 0;
    m_err = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    issue_valid = 1'b0; issue_src = '0; issue_dst = '0; issue_is_load = 1'b0;
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
  endtask

  task automatic settle();
    @(negedge CLK);
  endtask

  task automatic advance();
    m_commit();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    m_reset();
  endtask

  task automatic issue(input logic [3:0] s0, input logic [3:0] s1,
                       input logic [3:0] dst, input logic is_load);
    issue_valid = 1'b1; issue_src = {s1, s0}; issue_dst = dst; issue_is_load = is_load;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    for (int a = 0; a < 16; a += 5) begin
      issue_src = {4'(a + 1), 4'(a)};
      settle();
      n_cmp++; if (rd_data !== 32'h0) begin n_bad++; $display("FAIL reset_rd a=%0d: got %h want %h", a, rd_data, 32'h0); end
      n_cmp++; if (issue_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", issue_ready); end
      advance();
    end
    n_cmp++; if (load_count !== 2'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", load_count); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
  endtask

  task automatic test_bypass();
    set_idle();
    wb_valid = 1'b1; wb_addr = 4'd3; wb_data = 16'hBEEF; issue_src = {4'd0, 4'd3};
    settle();
    n_cmp++; if (rd_data[15:0] !== 16'hBEEF) begin n_bad++; $display("FAIL bypass_wb: got %h want BEEF", rd_data[15:0]); end
    advance();
    set_idle(); issue_src = {4'd3, 4'd3};
    settle();
    n_cmp++; if (rd_data !== 32'hBEEF_BEEF) begin n_bad++; $display("FAIL array_read: got %h want BEEFBEEF", rd_data); end
    advance();
  endtask

  task automatic test_load_stall();
    set_idle(); issue(4'd0, 4'd0, 4'd5, 1'b1);
    settle();
    n_cmp++; if (issue_ready !== 1'b1) begin n_bad++; $display("FAIL load5_issue_ready: got %b want 1", issue_ready); end
    advance();
    set_idle(); issue(4'd0, 4'd5, 4'd9, 1'b0);
    for (int c = 0; c < 3; c++) begin
      settle();
      n_cmp++; if (issue_ready !== 1'b0) begin n_bad++; $display("FAIL raw_stall c=%0d: got %b want 0", c, issue_ready); end
      n_cmp++; if (load_count !== 2'd1) begin n_bad++; $display("FAIL stall_count: got %0d want 1", load_count); end
      advance();
    end
    ld_valid = 1'b1; ld_addr = 4'd5; ld_data = 16'h0042;
    settle();
    n_cmp++; if (issue_ready !== 1'b1) begin n_bad++; $display("FAIL ld_return_ready: got %b want 1", issue_ready); end
    n_cmp++; if (rd_data[31:16] !== 16'h0042) begin n_bad++; $display("FAIL ld_bypass: got %h want 0042", rd_data[31:16]); end
    advance();
    set_idle();
    settle();
    n_cmp++; if (load_count !== 2'd0) begin n_bad++; $display("FAIL ld_count_dec: got %0d want 0", load_count); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL ld_clean_err: got %b want 0", err); end
    advance();
  endtask

  task automatic test_max_loads();
    set_idle(); issue(4'd10, 4'd11, 4'd1, 1'b1); advance();
    issue(4'd10, 4'd11, 4'd2, 1'b1); advance();
    issue(4'd10, 4'd11, 4'd4, 1'b1);
    settle();
    n_cmp++; if (issue_ready !== 1'b0) begin n_bad++; $display("FAIL max_loads_stall: got %b want 0", issue_ready); end
    n_cmp++; if (load_count !== 2'd2) begin n_bad++; $display("FAIL max_loads_count: got %0d want 2", load_count); end
    advance();
    issue(4'd10, 4'd11, 4'd6, 1'b0);
    settle();
    n_cmp++; if (issue_ready !== 1'b1) begin n_bad++; $display("FAIL alu_at_max: got %b want 1", issue_ready); end
    advance();
    issue(4'd10, 4'd11, 4'd4, 1'b1);
    ld_valid = 1'b1; ld_addr = 4'd1; ld_data = 16'h1111;
    settle();
    n_cmp++; if (issue_ready !== 1'b1) begin n_bad++; $display("FAIL load_with_return: got %b want 1", issue_ready); end
    advance();
    set_idle(); issue(4'd4, 4'd1, 4'd7, 1'b0);
    settle();
    n_cmp++; if (load_count !== 2'd2) begin n_bad++; $display("FAIL count_hold: got %0d want 2", load_count); end
    n_cmp++; if (issue_ready !== 1'b0) begin n_bad++; $display("FAIL r4_busy: got %b want 0", issue_ready); end
    n_cmp++; if (rd_data[31:16] !== 16'h1111) begin n_bad++; $display("FAIL r1_value: got %h want 1111", rd_data[31:16]); end
    advance();
    set_idle(); ld_valid = 1'b1; ld_addr = 4'd2; ld_data = 16'h2222; advance();
    ld_addr = 4'd4; ld_data = 16'h4444; advance();
    set_idle();
    settle();
    n_cmp++; if (load_count !== 2'd0) begin n_bad++; $display("FAIL drain_count: got %0d want 0", load_count); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL drain_err: got %b want 0", err); end
    advance();
  endtask

  task automatic test_err();
    set_idle(); ld_valid = 1'b1; ld_addr = 4'd7; ld_data = 16'h7777;
    settle();
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_before: got %b want 0", err); end
    advance();
    set_idle();
    settle();
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_idle_ld: got %b want 1", err); end
    n_cmp++; if (load_count !== 2'd0) begin n_bad++; $display("FAIL err_no_dec: got %0d want 0", load_count); end
    advance();
    wb_valid = 1'b1; wb_addr = 4'd8; wb_data = 16'hAAAA;
    ld_valid = 1'b1; ld_addr = 4'd8; ld_data = 16'h5555; issue_src = {4'd7, 4'd8};
    settle();
    n_cmp++; if (rd_data[15:0] !== 16'h5555) begin n_bad++; $display("FAIL collide_bypass: got %h want 5555", rd_data[15:0]); end
    advance();
    set_idle(); issue_src = {4'd7, 4'd8};
    repeat (3) begin
      settle();
      n_cmp++; if (rd_data !== 32'h7777_5555) begin n_bad++; $display("FAIL collide_array: got %h want 77775555", rd_data); end
      n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b want 1", err); end
      advance();
    end
    do_reset();
    settle();
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_reset: got %b want 0", err); end
    advance();
  endtask

  task automatic test_r0();
    set_idle(); wb_valid = 1'b1; wb_addr = 4'd0; wb_data = 16'hFFFF;
    settle();
    n_cmp++; if (rd_data[15:0] !== 16'h0) begin n_bad++; $display("FAIL r0_bypass: got %h want 0", rd_data[15:0]); end
    advance();
    set_idle(); issue(4'd0, 4'd0, 4'd0, 1'b1);
    settle();
    n_cmp++; if (rd_data !== 32'h0) begin n_bad++; $display("FAIL r0_array: got %h want 0", rd_data); end
    n_cmp++; if (issue_ready !== 1'b1) begin n_bad++; $display("FAIL r0_load_ready: got %b want 1", issue_ready); end
    advance();
    set_idle(); issue(4'd0, 4'd0, 4'd0, 1'b0);
    settle();
    n_cmp++; if (load_count !== 2'd0) begin n_bad++; $display("FAIL r0_count: got %0d want 0", load_count); end
    n_cmp++; if (issue_ready !== 1'b1) begin n_bad++; $display("FAIL r0_not_busy: got %b want 1", issue_ready); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL r0_err: got %b want 0", err); end
    advance();
  endtask

  task automatic test_random();
    int busy_q[$];
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (c % 100 == 99) do_reset();
      issue_valid   = 1'($urandom_range(0, 1));
      issue_src     = 8'($urandom_range(0, 255));
      issue_dst     = 4'($urandom_range(0, 15));
      issue_is_load = 1'($urandom_range(0, 1));
      wb_valid      = ($urandom_range(0, 3) == 0);
      wb_addr       = 4'($urandom_range(0, 15));
      wb_data       = 16'($urandom());
      ld_data       = 16'($urandom());
      ld_valid      = 1'b0;
      ld_addr       = 4'($urandom_range(0, 15));
      busy_q.delete();
      for (int r = 0; r < 16; r++) if (m_busy[r]) busy_q.push_back(r);
      if (busy_q.size() > 0 && $urandom_range(0, 2) == 0) begin
        ld_valid = 1'b1;
        ld_addr  = 4'(busy_q[$urandom_range(0, busy_q.size() - 1)]);
      end else if (!issue_is_load && $urandom_range(0, 29) == 0) begin
        ld_valid = 1'b1;
      end
      settle();
      n_cmp++; if (rd_data[15:0] !== m_read(int'(issue_src[3:0]))) begin n_bad++; $display("FAIL rand_rd0 c=%0d: got %h want %h", c, rd_data[15:0], m_read(int'(issue_src[3:0]))); end
      n_cmp++; if (rd_data[31:16] !== m_read(int'(issue_src[7:4]))) begin n_bad++; $display("FAIL rand_rd1 c=%0d: got %h want %h", c, rd_data[31:16], m_read(int'(issue_src[7:4]))); end
      n_cmp++; if (issue_ready !== m_ready()) begin n_bad++; $display("FAIL rand_ready c=%0d: got %b want %b", c, issue_ready, m_ready()); end
      n_cmp++; if (int'(load_count) != m_cnt || $isunknown(load_count)) begin n_bad++; $display("FAIL rand_count c=%0d: got %0d want %0d", c, load_count, m_cnt); end
      n_cmp++; if (err !== m_err) begin n_bad++; $display("FAIL rand_err c=%0d: got %b want %b", c, err, m_err); end
      advance();
    end
    set_idle();
  endtask

  // Sequencer and final report
  initial begin
    n_cmp = 0;
    n_bad = 0;
    set_idle();
    RST = 1'b1;
    m_reset();
    #1;
    test_reset();
    test_bypass();
    test_load_stall();
    test_max_loads();
    test_err();
    test_r0();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
